// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types for the FIFO enqueue-port arbiter: word width, requester count
// and the arbiter state encoding.
package fifo_types;

    localparam int WIDTH_P   = 8;
    localparam int NUM_REQ_P = 4;

    typedef logic [WIDTH_P-1:0]           word_t;
    typedef logic [$clog2(NUM_REQ_P)-1:0] req_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Requester-side and FIFO-side handshake bundle of the arbiter. The arbiter
// uses the slave view; the requesters and the FIFO together form the master.
interface fifo_rr_arbiter_if #(
    parameter int NUM_REQ_P = fifo_types::NUM_REQ_P,
    parameter int WIDTH_P   = fifo_types::WIDTH_P
);
    logic [NUM_REQ_P-1:0]              req_valid_i;
    logic [NUM_REQ_P-1:0][WIDTH_P-1:0] req_data_i;
    logic [NUM_REQ_P-1:0]              req_last_i;
    logic [NUM_REQ_P-1:0]              req_ready_o;
    logic                              enq_valid_o;
    logic [WIDTH_P-1:0]                enq_data_o;
    logic                              enq_ready_i;
    logic [NUM_REQ_P-1:0]              grant_o;
    logic                              locked_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, enq_ready_i,
        output req_ready_o, enq_valid_o, enq_data_o, grant_o, locked_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, enq_ready_i,
        input  req_ready_o, enq_valid_o, enq_data_o, grant_o, locked_o
    );
endinterface

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester starting at ptr_i,
// wrapping from NUM_REQ_P-1 back to 0.
module rr_pick #(
    parameter int NUM_REQ_P = fifo_types::NUM_REQ_P,
    localparam int IDX_W    = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1
) (
    input  logic [NUM_REQ_P-1:0] valid_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_REQ_P-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ_P - 1);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = ptr_i;
        for (int i = 0; i < NUM_REQ_P; i++) begin
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
    end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO enqueue port among
// NUM_REQ_P requesters; a multi-word or stalled packet holds the grant.
//
// state  | meaning
// IDLE   | no packet in flight; winner picked round-robin from ptr
// LOCKED | owner holds the port until it transfers a word with last set
module fifo_rr_arbiter #(
    parameter int NUM_REQ_P = fifo_types::NUM_REQ_P,
    parameter int WIDTH_P   = fifo_types::WIDTH_P
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    fifo_rr_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ_P - 1);

    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t wrap_inc(input idx_t idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    fifo_types::arb_state_e state_q, state_d;
    idx_t                   owner_q, owner_d;
    idx_t                   ptr_q, ptr_d;

    logic [NUM_REQ_P-1:0] pick_grant;
    idx_t                 pick_idx;
    logic                 pick_any;

    idx_t                 winner;
    logic                 has_winner;
    logic                 xfer;
    logic [NUM_REQ_P-1:0] grant;
    logic [NUM_REQ_P-1:0] ready;
    logic                 enq_valid;
    logic [WIDTH_P-1:0]   enq_data;

    rr_pick #(.NUM_REQ_P(NUM_REQ_P)) u_rr_pick (
        .valid_i (bus.req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= fifo_types::IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Outputs are gated by the raw reset so they read zero the moment it asserts.
    always_comb begin
        grant     = '0;
        ready     = '0;
        enq_valid = 1'b0;
        enq_data  = '0;
        if (state_q == fifo_types::LOCKED) begin
            winner     = owner_q;
            has_winner = 1'b1;
        end else begin
            winner     = pick_idx;
            has_winner = pick_any;
        end
        if (has_winner && reset_n_i) begin
            if (state_q == fifo_types::LOCKED) grant[winner] = 1'b1;
            else                               grant = pick_grant;
            enq_valid     = bus.req_valid_i[winner];
            enq_data      = bus.req_data_i[winner];
            ready[winner] = bus.enq_ready_i;
        end
        xfer = enq_valid && bus.enq_ready_i;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            fifo_types::IDLE: begin
                if (pick_any) begin
                    if (xfer && bus.req_last_i[pick_idx]) begin
                        ptr_d = wrap_inc(pick_idx);
                    end else begin
                        state_d = fifo_types::LOCKED;
                        owner_d = pick_idx;
                    end
                end
            end
            fifo_types::LOCKED: begin
                if (xfer && bus.req_last_i[owner_q]) begin
                    state_d = fifo_types::IDLE;
                    ptr_d   = wrap_inc(owner_q);
                end
            end
            default: state_d = fifo_types::IDLE;
        endcase
    end

    assign bus.grant_o     = grant;
    assign bus.req_ready_o = ready;
    assign bus.enq_valid_o = enq_valid;
    assign bus.enq_data_o  = enq_data;
    assign bus.locked_o    = reset_n_i && (state_q == fifo_types::LOCKED);
endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ_P, default 4, giving the number of requesters sharing one FIFO enqueue port.
REQ-002 SHALL have parameter WIDTH_P, default fifo_types::WIDTH_P (8), giving the word width.
REQ-003 SHALL have port clk_i  input  1  single clock, rising-edge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ_P  per-requester word valid.
REQ-006 SHALL have port req_data_i  input  NUM_REQ_P x WIDTH_P  per-requester word.
REQ-007 SHALL have port req_last_i  input  NUM_REQ_P  marks the final word of a requester's packet.
REQ-008 SHALL have port req_ready_o  output  NUM_REQ_P  per-requester accept.
REQ-009 SHALL have port enq_valid_o  output  1  word valid to the FIFO valid_i.
REQ-010 SHALL have port enq_data_o  output  WIDTH_P  word to the FIFO data_i.
REQ-011 SHALL have port enq_ready_i  input  1  connected to the FIFO ready_o.
REQ-012 SHALL have port grant_o  output  NUM_REQ_P  one-hot current grant, all-zero when nothing is granted.
REQ-013 SHALL have port locked_o  output  1  high while in LOCKED.

Function
REQ-014 A transfer on requester i SHALL occur when req_valid_i[i] and req_ready_o[i] are both high at a rising edge.
REQ-015 The FSM SHALL have states IDLE and LOCKED, with a registered owner index and a registered round-robin pointer ptr.
REQ-016 In IDLE, the winner SHALL be the first requester with req_valid_i high, searching ptr, ptr+1, ... modulo NUM_REQ_P; the selection is combinational with zero-cycle latency.
REQ-017 In LOCKED, the winner SHALL be owner regardless of the other req_valid_i values.
REQ-018 grant_o SHALL be one-hot on the winner; enq_valid_o = req_valid_i[winner]; enq_data_o = req_data_i[winner]; req_ready_o[winner] = enq_ready_i; all other req_ready_o bits SHALL be 0.
REQ-019 When there is no winner, grant_o, enq_valid_o and req_ready_o SHALL be 0, and enq_data_o SHALL be 0.
REQ-020 IDLE->LOCKED, owner<=winner: when the winner is valid and either no transfer occurs (stall) or a transfer occurs with req_last_i=0.
REQ-021 IDLE stay, ptr<=(winner+1) mod NUM_REQ_P: when the winner transfers with req_last_i=1 (single-word packet).
REQ-022 LOCKED->IDLE, ptr<=(owner+1) mod NUM_REQ_P: when owner transfers with req_last_i=1; otherwise the FSM SHALL remain in LOCKED.
REQ-023 The grant SHALL never change while enq_valid_o is high and enq_ready_i is low, so offered data is held stable until it is accepted.
REQ-024 A requester deasserting valid mid-packet in LOCKED SHALL keep the lock; there is no timeout.
REQ-025 ptr wrap SHALL go from NUM_REQ_P-1 to 0; ptr SHALL be $clog2(NUM_REQ_P) bits wide.
REQ-026 The block SHALL add no storage or latency to data; the FIFO full condition is expressed only through enq_ready_i=0.

Reset
REQ-027 reset_n_i low SHALL asynchronously force state=IDLE, ptr=0 and owner=0.
REQ-028 During reset, all outputs SHALL be 0.
REQ-029 Reset asserted mid-packet SHALL abandon the lock; after release, arbitration SHALL restart from requester 0.

Structure
REQ-030 NUM_REQ_P, req_idx_t and arb_state_e {IDLE, LOCKED} SHALL be added to package fifo_types, alongside WIDTH_P and word_t.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: valid vector and ptr; outputs: one-hot grant, index, any).

Verification
REQ-032 Scenario 1: reset low then released at a negedge, with all req_valid_i=1 and enq_ready_i=1 -> at the first posedge grant_o=0001 and locked_o=0.
REQ-033 Scenario 2: all four requesters send single-word packets (last=1) with data 8'hA0+i, enq_ready_i=1 -> FIFO receives A0, A1, A2, A3, A0, ... with one word per cycle.
REQ-034 Scenario 3: requester 2 sends a 3-word packet (last on word 3) while requesters 0 and 3 are valid -> words 2a, 2b, 2c are contiguous, then grant goes to 3, then 0.
REQ-035 Scenario 4: enq_ready_i held at 0 for 5 cycles while requester 1 is valid with 8'h5C -> grant_o=0010, enq_data_o=5C stable, and locked_o=1 throughout; the transfer occurs on the first cycle enq_ready_i=1.
REQ-036 Scenario 5: requester 0 drops valid after word 1 of a packet while requester 1 is valid -> grant is held on 0 and req_ready_o[1]=0 until requester 0 sends last.
REQ-037 Scenario 6: reset asserted in LOCKED with owner=3 -> outputs go to 0 immediately; after release, requester 0 is the first to be granted.
